// File: rtl/spectro_acq_core.sv
// Multi-channel threshold-triggered acquisition core with ping-pong sample banks and serial frame readout.
// Latency: signal_detected one cycle after the triggering sample_tick; the first frame bit appears with sending_data.
// Backpressure: a completed bank is held in S_HOLD until the reader is idle; triggers seen while holding are dropped and set overflow.
//
// Ports:
//   clk, rst_n         system clock, asynchronous active-low reset
//   sample_tick        strobe: sample ch_data (ch0 in LSBs), advance timestamp
//   shift_tick         strobe: advance serial_out by one bit
//   serial_out         frame bit (timestamp, then ch0..N_CH-1 samples, MSB first)
//   sync_time/sync_ch  markers for timestamp bits / first bit of each channel block
//   signal_detected    trigger pulse; mem_done: bank complete pulse
//   sending_pending    complete bank waiting for the reader; sending_data: frame in progress
//   write_bank/read_bank, state, overflow: status
// Optional feature: define CRC8_FRAME_EN to append a CRC-8 (poly 0x07, init 0) to every frame.
module spectro_acq_core #(
  parameter int N_CH     = 2,
  parameter int SAMPLE_W = 7,
  parameter int DEPTH    = 8,
  parameter int TS_W     = 12,
  parameter int THRESH   = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sample_tick,
  input  logic                     shift_tick,
  input  logic [N_CH*SAMPLE_W-1:0] ch_data,
  output logic                     serial_out,
  output logic                     sync_time,
  output logic                     sync_ch,
  output logic                     signal_detected,
  output logic                     mem_done,
  output logic                     sending_pending,
  output logic                     sending_data,
  output logic                     write_bank,
  output logic                     read_bank,
  output logic [1:0]               state,
  output logic                     overflow
);

  localparam int FRAME_LEN = TS_W + N_CH*DEPTH*SAMPLE_W;
`ifdef CRC8_FRAME_EN
  localparam int TOTAL_LEN = FRAME_LEN + 8;
`else
  localparam int TOTAL_LEN = FRAME_LEN;
`endif
  localparam int IDX_W  = $clog2(TOTAL_LEN);
  localparam int DIDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_REC  = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [TS_W-1:0]     r_ts;
  logic [DIDX_W-1:0]   r_wr_idx;
  logic                r_write_bank;
  logic                r_sig_det;
  logic                r_ovf;
  logic                r_sending;
  logic [IDX_W-1:0]    r_bit_idx;
  logic [FRAME_LEN-1:0] r_sr;
`ifdef CRC8_FRAME_EN
  logic [7:0]          r_crc;
`endif

  // Sample storage is intentionally not reset.
  logic [SAMPLE_W-1:0] r_mem [2][N_CH][DEPTH];
  logic [TS_W-1:0]     r_ts_bank [2];

  logic                 w_any_ge;
  logic                 w_wr_en;
  logic                 w_capture;
  logic                 w_start;
  logic                 w_set_ovf;
  logic [FRAME_LEN-1:0] w_frame;
  logic                 w_sync_ch;
  logic                 w_bit;

  always_comb begin
    w_any_ge = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (ch_data[c*SAMPLE_W +: SAMPLE_W] >= SAMPLE_W'(THRESH)) w_any_ge = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_WAIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_wr_en     = 1'b0;
    w_capture   = 1'b0;
    w_start     = 1'b0;
    w_set_ovf   = 1'b0;
    case (r_state)
      S_WAIT: begin
        if (sample_tick && w_any_ge) begin
          w_wr_en     = 1'b1;
          w_capture   = 1'b1;
          w_state_nxt = S_REC;
        end
      end
      S_REC: begin
        if (sample_tick) begin
          w_wr_en = 1'b1;
          if (r_wr_idx == DIDX_W'(DEPTH-1)) w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // The reader's registered busy flag decides; a frame ending this cycle still forces S_HOLD.
        if (!r_sending) begin
          w_start     = 1'b1;
          w_state_nxt = S_WAIT;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (sample_tick && w_any_ge) w_set_ovf = 1'b1;
        if (!r_sending) begin
          w_start     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      default: w_state_nxt = S_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ts         <= '0;
      r_wr_idx     <= '0;
      r_write_bank <= 1'b0;
      r_sig_det    <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      if (sample_tick) r_ts <= r_ts + TS_W'(1);
      if (w_wr_en) r_wr_idx <= (r_wr_idx == DIDX_W'(DEPTH-1)) ? '0 : r_wr_idx + DIDX_W'(1);
      if (w_start) r_write_bank <= ~r_write_bank;
      r_sig_det <= w_capture;
      if (w_set_ovf) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int c = 0; c < N_CH; c++) begin
        r_mem[r_write_bank][c][r_wr_idx] <= ch_data[c*SAMPLE_W +: SAMPLE_W];
      end
    end
    if (w_capture) r_ts_bank[r_write_bank] <= r_ts;
  end

  // Frame image of the bank being handed to the reader (the one just filled).
  always_comb begin
    w_frame = '0;
    w_frame[FRAME_LEN-1 -: TS_W] = r_ts_bank[r_write_bank];
    for (int c = 0; c < N_CH; c++) begin
      for (int d = 0; d < DEPTH; d++) begin
        w_frame[FRAME_LEN-1-TS_W-(c*DEPTH+d)*SAMPLE_W -: SAMPLE_W] = r_mem[r_write_bank][c][d];
      end
    end
  end

`ifdef CRC8_FRAME_EN
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    logic fb;
    fb = crc[7] ^ b;
    return {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sending <= 1'b0;
      r_bit_idx <= '0;
      r_sr      <= '0;
`ifdef CRC8_FRAME_EN
      r_crc     <= '0;
`endif
    end else if (w_start) begin
      r_sending <= 1'b1;
      r_bit_idx <= '0;
      r_sr      <= w_frame;
`ifdef CRC8_FRAME_EN
      r_crc     <= '0;
`endif
    end else if (r_sending && shift_tick) begin
      if (r_bit_idx == IDX_W'(TOTAL_LEN-1)) begin
        r_sending <= 1'b0;
        r_bit_idx <= '0;
      end else begin
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end
      r_sr <= r_sr << 1;
`ifdef CRC8_FRAME_EN
      // CRC accumulates over data bits, then is shifted out itself.
      if (r_bit_idx < IDX_W'(FRAME_LEN)) r_crc <= crc8_step(r_crc, r_sr[FRAME_LEN-1]);
      else                               r_crc <= {r_crc[6:0], 1'b0};
`endif
    end
  end

  always_comb begin
    w_sync_ch = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      if (r_bit_idx == IDX_W'(TS_W + c*DEPTH*SAMPLE_W)) w_sync_ch = 1'b1;
    end
  end

`ifdef CRC8_FRAME_EN
  assign w_bit = (r_bit_idx < IDX_W'(FRAME_LEN)) ? r_sr[FRAME_LEN-1] : r_crc[7];
`else
  assign w_bit = r_sr[FRAME_LEN-1];
`endif

  assign serial_out      = r_sending & w_bit;
  assign sync_time       = r_sending & (r_bit_idx < IDX_W'(TS_W));
  assign sync_ch         = r_sending & w_sync_ch;
  assign signal_detected = r_sig_det;
  assign mem_done        = (r_state == S_DONE);
  assign sending_pending = (r_state == S_HOLD);
  assign sending_data    = r_sending;
  assign write_bank      = r_write_bank;
  assign read_bank       = ~r_write_bank;
  assign state           = r_state;
  assign overflow        = r_ovf;

endmodule

// File: tb/tb_spectro_acq_core.sv
module tb_spectro_acq_core;

  localparam int FL = 12 + 2*8*7;
`ifdef CRC8_FRAME_EN
  localparam int TOT = FL + 8;
`else
  localparam int TOT = FL;
`endif

  logic        clk;
  logic        rst_n;
  logic        sample_tick;
  logic        shift_tick;
  logic [13:0] ch_data;
  logic        serial_out, sync_time, sync_ch, signal_detected, mem_done;
  logic        sending_pending, sending_data, write_bank, read_bank, overflow;
  logic [1:0]  state;

  spectro_acq_core dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .shift_tick(shift_tick),
    .ch_data(ch_data), .serial_out(serial_out), .sync_time(sync_time), .sync_ch(sync_ch),
    .signal_detected(signal_detected), .mem_done(mem_done), .sending_pending(sending_pending),
    .sending_data(sending_data), .write_bank(write_bank), .read_bank(read_bank),
    .state(state), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int             m_ts;
  logic           m_wb;
  logic [TOT-1:0] exp_q[$];
  logic [6:0]     ev_s [2][8];
  logic [TOT-1:0] exp_t, exp_c;
  logic [TOT-1:0] obs, ot, oc;
  int             rd_i;

  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, o, e);
    end
  endtask

  function automatic logic [TOT-1:0] build_frame(input logic [11:0] ts);
    logic [FL-1:0] f;
    f = FL'(ts);
    for (int c = 0; c < 2; c++)
      for (int d = 0; d < 8; d++)
        f = (f << 7) | FL'(ev_s[c][d]);
`ifdef CRC8_FRAME_EN
    begin
      logic [7:0] crc;
      logic fb;
      crc = 8'h00;
      for (int i = FL-1; i >= 0; i--) begin
        fb  = crc[7] ^ f[i];
        crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
      end
      return {f, crc};
    end
`else
    return f;
`endif
  endfunction

  function automatic logic [13:0] rq();
    return {7'($urandom_range(0, 63)), 7'($urandom_range(0, 63))};
  endfunction

  function automatic logic [13:0] rnd_any();
    return {7'($urandom_range(0, 127)), 7'($urandom_range(0, 127))};
  endfunction

  function automatic logic [13:0] rnd_trig();
    int k;
    k = $urandom_range(0, 2);
    if (k == 0) return {7'($urandom_range(0, 63)),   7'($urandom_range(64, 127))};
    if (k == 1) return {7'($urandom_range(64, 127)), 7'($urandom_range(0, 63))};
    return {7'($urandom_range(64, 127)), 7'($urandom_range(64, 127))};
  endfunction

  task automatic check_frame();
    chk("frame_len", 256'(rd_i), 256'(TOT));
    chk("frame_queued", 256'(exp_q.size() > 0), 256'(1));
    if (exp_q.size() > 0) chk("frame_bits", obs, exp_q.pop_front());
    chk("sync_time_mask", ot, exp_t);
    chk("sync_ch_mask", oc, exp_c);
    chk("idle_outputs", {serial_out, sync_time, sync_ch}, 3'b000);
  endtask

  // One clock: drive inputs, capture the bit consumed by a shift_tick, evaluate after the edge.
  task automatic cyc(input bit st, input bit sh, input logic [13:0] d);
    bit was;
    sample_tick = st;
    shift_tick  = sh;
    ch_data     = d;
    was = sending_data;
    if (sh && was && rd_i < TOT) begin
      obs[TOT-1-rd_i] = serial_out;
      ot[TOT-1-rd_i]  = sync_time;
      oc[TOT-1-rd_i]  = sync_ch;
      rd_i++;
    end
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    shift_tick  = 1'b0;
    if (st) m_ts = (m_ts + 1) % 4096;
    if (!was && sending_data) begin
      rd_i = 0; obs = '0; ot = '0; oc = '0;
    end
    if (was && !sending_data) check_frame();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    m_ts = 0; m_wb = 1'b0; rd_i = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Trigger plus DEPTH-1 further samples; the expected frame is queued from the data driven.
  task automatic do_event(input bit sh, input logic [13:0] trig_d, input bit ramp);
    logic [11:0] ets;
    logic [13:0] dd;
    bit first;
    ets = 12'(m_ts);
    ev_s[0][0] = trig_d[6:0];
    ev_s[1][0] = trig_d[13:7];
    cyc(1'b1, sh, trig_d);
    chk("trigger_detect", {signal_detected, state}, {1'b1, 2'd1});
    first = 1'b1;
    for (int d = 1; d < 8; d++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        cyc(1'b0, sh, rnd_any());
        if (first) begin chk("sig_pulse_len", signal_detected, 1'b0); first = 1'b0; end
      end
      dd = ramp ? {7'(70 + 7*d), 7'(3 + 5*d)} : rnd_any();
      ev_s[0][d] = dd[6:0];
      ev_s[1][d] = dd[13:7];
      cyc(1'b1, sh, dd);
      if (first) begin chk("sig_pulse_len", signal_detected, 1'b0); first = 1'b0; end
    end
    chk("mem_done", {mem_done, state}, {1'b1, 2'd2});
    exp_q.push_back(build_frame(ets));
  endtask

  task automatic expect_swap(input string tag);
    cyc(1'b0, 1'b0, rq());
    m_wb = ~m_wb;
    chk(tag, {write_bank, read_bank, sending_data, state, sending_pending},
        {m_wb, ~m_wb, 1'b1, 2'd0, 1'b0});
  endtask

  task automatic read_all();
    int n;
    n = 0;
    while (sending_data && n < 1000) begin
      cyc(1'b0, 1'b1, rq());
      if (sending_data && $urandom_range(0, 3) == 0) cyc(1'b0, 1'b0, rq());
      n++;
    end
    chk("read_finished", sending_data, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    for (int i = 0; i < TOT; i++) begin
      exp_t[TOT-1-i] = (i < 12);
      exp_c[TOT-1-i] = 1'b0;
      for (int c = 0; c < 2; c++) if (i == 12 + c*56) exp_c[TOT-1-i] = 1'b1;
    end
    sample_tick = 1'b0; shift_tick = 1'b0; ch_data = '0;
    obs = '0; ot = '0; oc = '0;
    do_reset();
    chk("reset_outputs",
        {serial_out, sync_time, sync_ch, signal_detected, mem_done, sending_pending,
         sending_data, write_bank, read_bank, state, overflow},
        {7'b0, 1'b0, 1'b1, 2'b00, 1'b0});

    // Quiet data below threshold: nothing happens, timestamp runs to 20.
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 1'b0, rq());
      if (signal_detected || state != 2'd0) seen = 1'b1;
    end
    chk("quiet_no_trigger", seen, 1'b0);
    do_event(1'b0, rnd_trig(), 1'b0);
    expect_swap("swap_ev1");
    read_all();

    // Ramp event triggered by ch1=70 at ts=5.
    do_reset();
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, rq());
    do_event(1'b0, {7'd70, 7'd3}, 1'b1);
    expect_swap("swap_ramp");
    read_all();

    // Second event completes while the first streams; held, then an overflowing trigger.
    do_event(1'b0, rnd_trig(), 1'b0);
    expect_swap("swap_a");
    do_event(1'b1, rnd_trig(), 1'b0);
    cyc(1'b0, 1'b1, rq());
    chk("hold_entry", {state, sending_pending, mem_done}, {2'd3, 1'b1, 1'b0});
    cyc(1'b1, 1'b1, {7'd100, 7'd0});
    chk("overflow_set", {overflow, state, signal_detected}, {1'b1, 2'd3, 1'b0});
    read_all();
    chk("hold_at_fall", {state, sending_data}, {2'd3, 1'b0});
    expect_swap("swap_after_hold");
    read_all();
    chk("overflow_sticky", overflow, 1'b1);

    // Timestamp wrap: event at 4095, then one after the wrap; threshold boundary 64.
    do_reset();
    chk("overflow_cleared", overflow, 1'b0);
    for (int i = 0; i < 4095; i++) cyc(1'b1, 1'b0, rq());
    do_event(1'b0, rnd_trig(), 1'b0);
    expect_swap("swap_wrap");
    read_all();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, rq());
    do_event(1'b0, {7'd0, 7'd64}, 1'b0);
    expect_swap("swap_post_wrap");
    read_all();

    // Reset in the middle of a frame.
    do_event(1'b0, rnd_trig(), 1'b0);
    expect_swap("swap_mid");
    for (int i = 0; i < 60; i++) cyc(1'b0, 1'b1, rq());
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs",
        {serial_out, sync_time, sync_ch, signal_detected, mem_done, sending_pending,
         sending_data, write_bank, read_bank, state, overflow},
        {7'b0, 1'b0, 1'b1, 2'b00, 1'b0});
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, rq());
    chk("no_resend", {sending_data, state}, {1'b0, 2'd0});
    do_event(1'b0, rnd_trig(), 1'b0);
    expect_swap("swap_clean");
    read_all();
    chk("all_frames_seen", 256'(exp_q.size()), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
